// File: rtl/mmio_bridge_if.sv
// CPU data-port and MMIO-side signals of mmio_bridge grouped as one bundle.
// slave = bridge view; master = CPU plus MMIO subsystem view.
interface mmio_bridge_if #(
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 cpu_req;
    logic                 cpu_we;
    logic [31:0]          cpu_addr;
    logic [3:0]           cpu_be;
    logic [31:0]          cpu_wdata;
    logic                 cpu_ready;
    logic                 cpu_rvalid;
    logic [31:0]          cpu_rdata;
    logic                 cpu_err;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 mmio_cs;
    logic                 mmio_wr;
    logic                 mmio_rd;
    logic [20:0]          mmio_addr;
    logic [31:0]          mmio_wr_data;
    logic [31:0]          mmio_rd_data;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, mmio_rd_data,
        output cpu_ready, cpu_rvalid, cpu_rdata, cpu_err, err_count,
               mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, mmio_rd_data,
        input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_err, err_count,
               mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
    );
endinterface

// File: rtl/mmio_bridge.sv
// Single-beat CPU-to-MMIO bridge: decodes the I/O window, strobes MMIO for one cycle, returns a response.
// Optional macro BRIDGE_POSTED_WR_EN: writes skip the response cycle (no cpu_rvalid).
module mmio_bridge #(
    parameter logic [31:0] BRIDGE_BASE = 32'hC000_0000,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input logic         clk,
    input logic         reset,
    mmio_bridge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

    state_t               state, state_nxt;
    logic [31:2]          req_addr;
    logic [31:0]          req_wdata;
    logic [3:0]           req_be;
    logic                 req_we;
    logic [31:0]          rdata_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 accept;
    logic                 req_legal;
    logic                 strobe;

    assign accept    = (state == IDLE) && bus.cpu_req;
    assign req_legal = (req_addr[31:23] == BRIDGE_BASE[31:23]) &&
                       (!req_we || (req_be == 4'hF));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.cpu_req) state_nxt = ACC;
`ifdef BRIDGE_POSTED_WR_EN
            ACC:  state_nxt = req_we ? IDLE : RSP;
`else
            ACC:  state_nxt = RSP;
`endif
            RSP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        strobe         = (state == ACC) && req_legal;
        bus.cpu_ready  = (state == IDLE);
        bus.cpu_rvalid = (state == RSP);
        bus.mmio_cs    = strobe;
        bus.mmio_wr    = strobe && req_we;
        bus.mmio_rd    = strobe && !req_we;
    end

    // Request is latched only on accept, so mmio_addr/mmio_wr_data hold between accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            req_we    <= 1'b0;
        end else if (accept) begin
            req_addr  <= bus.cpu_addr[31:2];
            req_wdata <= bus.cpu_wdata;
            req_be    <= bus.cpu_be;
            req_we    <= bus.cpu_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (state == ACC) begin
            rdata_q <= (req_legal && !req_we) ? bus.mmio_rd_data : '0;
            err_q   <= !req_legal;
            if (!req_legal && (err_cnt_q != '1))
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.mmio_addr    = req_addr[22:2];
    assign bus.mmio_wr_data = req_wdata;
    assign bus.cpu_rdata    = rdata_q;
    assign bus.cpu_err      = err_q;
    assign bus.err_count    = err_cnt_q;
endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

CPU-side bus bridge that sits directly upstream of the MMIO subsystem. It accepts single-beat requests from the processor data port over a valid/ready handshake and decodes the I/O window. Each request becomes a one-cycle mmio_cs/mmio_wr/mmio_rd strobe with a word address. For reads, it captures mmio_rd_data and returns it to the CPU with an explicit response pulse.

## Interface
- BRIDGE_BASE, 32'hC000_0000, base byte address of the I/O window; bits [31:23] are compared, so the window is 8 MiB.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  request valid.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_be  in  4  byte enables; writes require 4'hF.
- cpu_wdata  in  32  write data.
- cpu_ready  out  1  request accepted when cpu_req & cpu_ready.
- cpu_rvalid  out  1  one-cycle response pulse.
- cpu_rdata  out  32  response data; valid with cpu_rvalid.
- cpu_err  out  1  response error flag; valid with cpu_rvalid.
- err_count  out  ERR_CNT_W  saturating count of errored accesses.
- mmio_cs  out  1  MMIO chip select.
- mmio_wr  out  1  MMIO write strobe.
- mmio_rd  out  1  MMIO read strobe.
- mmio_addr  out  21  word address, equal to cpu_addr[22:2].
- mmio_wr_data  out  32  write data.
- mmio_rd_data  in  32  read data, combinational from the MMIO subsystem.

## Operation
- FSM states: IDLE, ACC, RSP.
  - IDLE: cpu_ready=1. On cpu_req, register addr, we, be and wdata, then go to ACC.
  - ACC: drive the strobes from the registered request. Capture mmio_rd_data into cpu_rdata, compute the error flag, then go to RSP.
  - RSP: cpu_rvalid=1 for exactly one cycle, then go to IDLE.
- Hit condition: cpu_addr[31:23] == BRIDGE_BASE[31:23].
- Legal access (hit, and for writes be==4'hF), in ACC:
  - mmio_cs=1.
  - mmio_wr=we.
  - mmio_rd=~we.
  - mmio_addr=addr[22:2].
  - mmio_wr_data=wdata.
- Miss, or write with be!=4'hF:
  - mmio_cs, mmio_wr and mmio_rd stay 0 in ACC.
  - The response carries cpu_err=1 and cpu_rdata=0.
  - err_count increments by 1 and saturates at all-ones.
- Reads ignore cpu_be and addr[1:0] and return the full word.
- Writes respond with cpu_rdata=0 and cpu_err=0.
- Outside ACC, mmio_cs/mmio_wr/mmio_rd=0. mmio_addr and mmio_wr_data hold their last registered value.

## Timing
- Reset values:
  - state=IDLE, so cpu_ready=1 in the first cycle after reset.
  - cpu_rvalid=0, cpu_rdata=0, cpu_err=0, err_count=0.
  - mmio_cs/mmio_wr/mmio_rd=0, mmio_addr=0, mmio_wr_data=0.
- Latency: accept edge T, strobe in cycle T+1, cpu_rvalid in cycle T+2. Next accept no earlier than T+3.
- cpu_ready is a decode of state (IDLE only). The CPU may hold cpu_req high; it is sampled only in IDLE.
- cpu_rdata and cpu_err are registered at the end of ACC and hold until the next ACC.
- Reset asserted in ACC or RSP:
  - Next state is IDLE.
  - No cpu_rvalid is issued for the aborted access.
  - The strobe already driven in ACC is not retracted; that bus write may have taken effect.
- Reset has priority over an accept in the same cycle.

## Configuration
- BRIDGE_POSTED_WR_EN defined:
  - A legal or errored write goes IDLE→ACC→IDLE with no RSP cycle and no cpu_rvalid.
  - Write throughput is one per 2 cycles.
  - Write errors are visible only through err_count.
  - Reads are unchanged.
- BRIDGE_POSTED_WR_EN undefined: every access, read or write, produces exactly one cpu_rvalid pulse.

## Test plan
- Write 0xC000_0100, data 0x0000_00A5, be=F -> in cycle T+1: mmio_cs=1, mmio_wr=1, mmio_addr=0x040, mmio_wr_data=0xA5; the slot-2 LED register becomes 0xA5. cpu_rvalid at T+2 only when BRIDGE_POSTED_WR_EN is undefined.
- Read 0xC000_0180 with the slot returning 0x0000_003C -> mmio_rd=1 and mmio_addr=0x060 at T+1; cpu_rvalid=1, cpu_rdata=0x3C, cpu_err=0 at T+2.
- Read 0x8000_0000 (miss) -> no strobes; cpu_rvalid at T+2 with cpu_err=1 and cpu_rdata=0; err_count=1.
- Write 0xC000_0100 with be=4'h3 -> no mmio_wr; err_count increments. cpu_err=1 response only when BRIDGE_POSTED_WR_EN is undefined.
- cpu_req held high for 300 missed reads -> cpu_ready pattern is 1,0,0 repeating; err_count saturates at 0xFF.
- Reset asserted in ACC of a read -> IDLE next cycle, cpu_ready=1, and no cpu_rvalid pulse ever appears for that read.
